// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC/fetch sequencer.
package pc_seq_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
  } pc_state_t;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential next-PC adder; wraps modulo 2^XLEN with no carry out.
module pc_incrementer
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o
);

  assign pc_next_o = pc_i + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: issues fetches, holds the fetched word for decode,
// and selects the next PC from sequential, redirect, trap vector or halt.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
  output logic            misalign_trap
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] pc_plus4;

  pc_incrementer u_pc_inc (
    .pc_i      (pc_q),
    .pc_next_o (pc_plus4)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    trap_d     = trap_q;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        // A stalled ISSUE freezes everything; next-PC inputs matter only on release.
        if (!stall) begin
          if (halt) begin
            state_d = HALT;
          end else if (redirect_valid) begin
            if (is_aligned(redirect_target)) begin
              pc_d = redirect_target;
            end else begin
              pc_d   = TRAP_VEC;
              trap_d = 1'b1;
            end
            state_d = FETCH;
          end else begin
            pc_d    = pc_plus4;
            state_d = FETCH;
          end
        end
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      trap_q     <= trap_d;
    end
  end

  assign imem_req      = (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == ISSUE);
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed cycle-table bench for pc_fetch_sequencer plus latency/streaming sequences.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        misalign_trap;

  int checks   = 0;
  int failures = 0;

  pc_fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .misalign_trap   (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        halt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic        trap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic a, input logic [31:0] d,
                     input logic s, input logic v, input logic [31:0] t, input logic h,
                     input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                     input logic [31:0] e_ins, input logic [31:0] e_ipc, input logic e_trap);
    vec_t x;
    x.rst = r; x.ack = a; x.rdata = d; x.stall = s; x.rv = v; x.rt = t; x.halt = h;
    x.req = e_req; x.addr = e_addr; x.vld = e_vld; x.ins = e_ins; x.ipc = e_ipc; x.trap = e_trap;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic s, input logic v, input logic [31:0] t, input logic h);
    rst = r; imem_ack = a; imem_rdata = d; stall = s;
    redirect_valid = v; redirect_target = t; halt = h;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    int n;
    logic [31:0] exp_pc;
    logic [31:0] key;

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    //  rst ack rdata         stl rv  target         hlt | req addr          vld instr         instr_pc      trap
    add(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,          0, NOP,          32'h0,          0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          0, NOP,          32'h0,          0);
    add(0, 1, 32'h0000_A0A0,  0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0000_A0A0, 32'h0,          0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0000_A0A0, 32'h0,          0);
    add(0, 1, 32'h0000_A1A1,  0, 0, 32'h0,          0,   0, 32'h4,          1, 32'h0000_A1A1, 32'h4,          0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h8,          0, 32'h0000_A1A1, 32'h4,          0);
    // three wait cycles at 0x8
    add(0, 0, 32'hBAD0_0001,  0, 0, 32'h0,          0,   1, 32'h8,          0, 32'h0000_A1A1, 32'h4,          0);
    add(0, 0, 32'hBAD0_0002,  0, 0, 32'h0,          0,   1, 32'h8,          0, 32'h0000_A1A1, 32'h4,          0);
    add(0, 0, 32'hBAD0_0003,  0, 0, 32'h0,          0,   1, 32'h8,          0, 32'h0000_A1A1, 32'h4,          0);
    add(0, 1, 32'h0000_A2A2,  0, 0, 32'h0,          0,   0, 32'h8,          1, 32'h0000_A2A2, 32'h8,          0);
    // aligned then misaligned redirect
    add(0, 0, 32'h0,          0, 1, 32'h40,         0,   1, 32'h40,         0, 32'h0000_A2A2, 32'h8,          0);
    add(0, 1, 32'h0000_B0B0,  0, 0, 32'h0,          0,   0, 32'h40,         1, 32'h0000_B0B0, 32'h40,         0);
    add(0, 0, 32'h0,          0, 1, 32'h42,         0,   1, 32'h100,        0, 32'h0000_B0B0, 32'h40,         1);
    add(0, 1, 32'h0000_C0C0,  0, 0, 32'h0,          0,   0, 32'h100,        1, 32'h0000_C0C0, 32'h100,        1);
    // stall with pulsing redirect, stray ack and masked halt
    add(0, 0, 32'h0,          1, 1, 32'h200,        0,   0, 32'h100,        1, 32'h0000_C0C0, 32'h100,        1);
    add(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          0,   0, 32'h100,        1, 32'h0000_C0C0, 32'h100,        1);
    add(0, 0, 32'h0,          1, 1, 32'h200,        0,   0, 32'h100,        1, 32'h0000_C0C0, 32'h100,        1);
    add(0, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h100,        1, 32'h0000_C0C0, 32'h100,        1);
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h104,        0, 32'h0000_C0C0, 32'h100,        1);
    add(0, 1, 32'h0000_C1C1,  0, 0, 32'h0,          0,   0, 32'h104,        1, 32'h0000_C1C1, 32'h104,        1);
    // redirect still present when stall drops is taken
    add(0, 0, 32'h0,          1, 1, 32'h300,        0,   0, 32'h104,        1, 32'h0000_C1C1, 32'h104,        1);
    add(0, 0, 32'h0,          0, 1, 32'h300,        0,   1, 32'h300,        0, 32'h0000_C1C1, 32'h104,        1);
    add(0, 0, 32'h0,          0, 1, 32'h500,        1,   1, 32'h300,        0, 32'h0000_C1C1, 32'h104,        1);
    add(0, 1, 32'h0000_D0D0,  0, 0, 32'h0,          0,   0, 32'h300,        1, 32'h0000_D0D0, 32'h300,        1);
    // halt wins over redirect; acks in HALT ignored
    add(0, 0, 32'h0,          0, 1, 32'h400,        1,   0, 32'h300,        0, 32'h0000_D0D0, 32'h300,        1);
    add(0, 1, 32'h0000_EEEE,  0, 0, 32'h0,          0,   0, 32'h300,        0, 32'h0000_D0D0, 32'h300,        1);
    add(0, 0, 32'h0,          0, 1, 32'h600,        0,   0, 32'h300,        0, 32'h0000_D0D0, 32'h300,        1);
    add(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,          0, NOP,          32'h0,          0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          0, NOP,          32'h0,          0);
    add(0, 1, 32'h0000_F0F0,  0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0000_F0F0, 32'h0,          0);
    // wrap at top of address space
    add(0, 0, 32'h0,          0, 1, 32'hFFFF_FFFC,  0,   1, 32'hFFFF_FFFC,  0, 32'h0000_F0F0, 32'h0,          0);
    add(0, 1, 32'h0000_F1F1,  0, 0, 32'h0,          0,   0, 32'hFFFF_FFFC,  1, 32'h0000_F1F1, 32'hFFFF_FFFC,  0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0000_F1F1, 32'hFFFF_FFFC,  0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0000_F1F1, 32'hFFFF_FFFC,  0);
    // reset during pending fetch, then ack in IDLE ignored
    add(1, 1, 32'h0000_7777,  0, 0, 32'h0,          0,   0, 32'h0,          0, NOP,          32'h0,          0);
    add(0, 1, 32'h0000_9999,  0, 0, 32'h0,          0,   1, 32'h0,          0, NOP,          32'h0,          0);
    add(0, 1, 32'h0000_5555,  0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0000_5555, 32'h0,          0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].stall,
            vecs[i].rv, vecs[i].rt, vecs[i].halt);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_req", i),   {31'b0, imem_req},      {31'b0, vecs[i].req});
      chk($sformatf("row%0d_addr", i),  imem_addr,              vecs[i].addr);
      chk($sformatf("row%0d_valid", i), {31'b0, instr_valid},   {31'b0, vecs[i].vld});
      chk($sformatf("row%0d_instr", i), instr,                  vecs[i].ins);
      chk($sformatf("row%0d_ipc", i),   instr_pc,               vecs[i].ipc);
      chk($sformatf("row%0d_trap", i),  {31'b0, misalign_trap}, {31'b0, vecs[i].trap});
    end

    // Request latency after reset: IDLE for one cycle, then FETCH.
    @(negedge clk);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_req_in_idle", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (imem_req) break;
      @(negedge clk);
    end
    chk("lat_req_cycles", n, 32'd1);
    chk("lat_req_high", {31'b0, imem_req}, 32'd1);

    // Zero-wait streaming: one instruction every two cycles.
    exp_pc = 32'h0;
    key    = 32'hA5A5_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = exp_pc ^ key;
      @(posedge clk);
      #1;
      if ((i % 2) == 0) begin
        chk($sformatf("stream%0d_valid", i), {31'b0, instr_valid}, 32'd1);
        chk($sformatf("stream%0d_ipc", i),   instr_pc,             exp_pc);
        chk($sformatf("stream%0d_instr", i), instr,                exp_pc ^ key);
      end else begin
        exp_pc = exp_pc + 32'd4;
        chk($sformatf("stream%0d_valid", i), {31'b0, instr_valid}, 32'd0);
        chk($sformatf("stream%0d_addr", i),  imem_addr,            exp_pc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
